exposure_sequencer: RTL and testbench

//  Sequences one CCD exposure: optional pre-flush, open shutter, timed integrate, close shutter,

---
 rtl/exposure_sequencer_pkg.sv | 30 +++
 rtl/exposure_sequencer_ms_timer.sv | 47 ++++
 rtl/exposure_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_exposure_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/exposure_sequencer_pkg.sv
// Shared definitions for the exposure sequencer: FSM states, status codes, readout modes.
package exposure_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FLUSH_REQ,
        ST_FLUSH_WAIT,
        ST_OPEN_SETTLE,
        ST_EXPOSE,
        ST_CLOSE_SETTLE,
        ST_READ_REQ,
        ST_READ_WAIT,
        ST_FINISH
    } state_e;

    localparam logic [1:0] STATUS_OK    = 2'b00;
    localparam logic [1:0] STATUS_ABORT = 2'b01;
    localparam logic [1:0] STATUS_TMO   = 2'b10;

    localparam logic [1:0] MODE_FULL  = 2'b00;
    localparam logic [1:0] MODE_FLUSH = 2'b01;

    localparam int unsigned MS_W = 24;

    // States whose duration is measured by the ms timebase.
    function automatic logic is_timed(input state_e s);
        return (s == ST_OPEN_SETTLE) || (s == ST_EXPOSE) || (s == ST_CLOSE_SETTLE);
    endfunction

endpackage

// File: rtl/exposure_sequencer_ms_timer.sv
// Millisecond timebase: prescaler plus 24-bit ms counter; clr restarts it and loads the
// duration N, expired_o pulses on the last cycle of N*CLK_PER_MS (immediately when N == 0).
module exposure_sequencer_ms_timer
    import exposure_sequencer_pkg::*;
#(
    parameter int unsigned CLK_PER_MS = 100000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic [MS_W-1:0] n_i,
    input  logic            run_i,
    output logic            expired_o
);

    localparam int unsigned PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    logic [PW-1:0]   pre_q;
    logic [MS_W-1:0] ms_q;
    logic [MS_W-1:0] n_q;
    logic            pre_last;
    logic            ms_last;

    assign pre_last  = (pre_q == PW'(CLK_PER_MS - 1));
    assign ms_last   = ((ms_q + MS_W'(1)) == n_q);
    assign expired_o = run_i && ((n_q == '0) || (pre_last && ms_last));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            ms_q  <= '0;
            n_q   <= '0;
        end else if (clr_i) begin
            pre_q <= '0;
            ms_q  <= '0;
            n_q   <= n_i;
        end else if (run_i) begin
            if (pre_last) begin
                pre_q <= '0;
                ms_q  <= ms_q + MS_W'(1);
            end else begin
                pre_q <= pre_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/exposure_sequencer.sv
// Exposure sequencer: shutter open/settle, timed integrate, close/settle, CCD readout handshake.
// Define EXPSEQ_FLUSH_EN to build the pre-exposure CCD flush (FLUSH_REQ/FLUSH_WAIT).
module exposure_sequencer
    import exposure_sequencer_pkg::*;
#(
    parameter int unsigned CLK_PER_MS = 100000,
    parameter int unsigned SETTLE_MS  = 300,
    parameter int unsigned BUSY_TMO   = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            dark,
    input  logic [MS_W-1:0] exp_ms,
    input  logic            ccd_busy,
    output logic            ccd_toggle,
    output logic [1:0]      ccd_mode,
    output logic            shutter_open,
    output logic            busy,
    output logic            done,
    output logic [1:0]      status
);

    localparam int unsigned TW = $clog2(BUSY_TMO + 1);

    state_e          state_q, state_d;
    logic [MS_W-1:0] exp_q, exp_d, exp_src, tmr_n;
    logic            closed_q, closed_d;
    logic            abort_q, abort_d;
    logic            seen_q, seen_d;
    logic [1:0]      status_q, status_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            tmr_clr, tmr_run, tmr_exp;
    logic            aborting, busy_fell, tmo_hit, in_wait;

    exposure_sequencer_ms_timer #(.CLK_PER_MS(CLK_PER_MS)) u_ms_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (tmr_clr),
        .n_i       (tmr_n),
        .run_i     (tmr_run),
        .expired_o (tmr_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            exp_q    <= '0;
            closed_q <= 1'b0;
            abort_q  <= 1'b0;
            seen_q   <= 1'b0;
            status_q <= STATUS_OK;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            closed_q <= closed_d;
            abort_q  <= abort_d;
            seen_q   <= seen_d;
            status_q <= status_d;
            tmo_q    <= tmo_d;
        end
    end

    // A busy level already present in the REQ cycle counts as the rising edge.
    assign in_wait   = (state_q == ST_FLUSH_WAIT) || (state_q == ST_READ_WAIT);
    assign aborting  = abort_q || abort;
    assign busy_fell = seen_q && !ccd_busy;
    assign tmo_hit   = !seen_q && !ccd_busy && (tmo_q == TW'(BUSY_TMO - 1));

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        closed_d = closed_q;
        abort_d  = abort_q;
        seen_d   = seen_q;
        status_d = status_q;
        tmo_d    = tmo_q;

        if (in_wait) begin
            abort_d = aborting;
            if (!seen_q) begin
                seen_d = ccd_busy;
                tmo_d  = tmo_q + TW'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    exp_d    = exp_ms;
                    closed_d = dark || (exp_ms == '0);
                    abort_d  = 1'b0;
                    status_d = STATUS_OK;
`ifdef EXPSEQ_FLUSH_EN
                    state_d  = ST_FLUSH_REQ;
`else
                    state_d  = (dark || (exp_ms == '0)) ? ST_EXPOSE : ST_OPEN_SETTLE;
`endif
                end
            end
`ifdef EXPSEQ_FLUSH_EN
            ST_FLUSH_REQ: begin
                seen_d = ccd_busy;
                tmo_d  = TW'(1);
                if (abort) begin
                    abort_d = 1'b1;
                    state_d = ST_CLOSE_SETTLE;
                end else begin
                    state_d = ST_FLUSH_WAIT;
                end
            end
            ST_FLUSH_WAIT: begin
                if (tmo_hit) begin
                    status_d = STATUS_TMO;
                    state_d  = ST_FINISH;
                end else if (busy_fell) begin
                    if (aborting) begin
                        status_d = STATUS_ABORT;
                        state_d  = ST_FINISH;
                    end else begin
                        state_d = closed_q ? ST_EXPOSE : ST_OPEN_SETTLE;
                    end
                end
            end
`endif
            ST_OPEN_SETTLE: begin
                if (abort) begin
                    abort_d = 1'b1;
                    state_d = ST_CLOSE_SETTLE;
                end else if (tmr_exp) begin
                    state_d = ST_EXPOSE;
                end
            end
            ST_EXPOSE: begin
                if (abort) begin
                    abort_d = 1'b1;
                    state_d = ST_CLOSE_SETTLE;
                end else if (tmr_exp) begin
                    state_d = closed_q ? ST_READ_REQ : ST_CLOSE_SETTLE;
                end
            end
            ST_CLOSE_SETTLE: begin
                abort_d = aborting;
                if (tmr_exp) begin
                    if (aborting) begin
                        status_d = STATUS_ABORT;
                        state_d  = ST_FINISH;
                    end else begin
                        state_d = ST_READ_REQ;
                    end
                end
            end
            ST_READ_REQ: begin
                seen_d  = ccd_busy;
                tmo_d   = TW'(1);
                abort_d = aborting;
                state_d = ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
                if (tmo_hit) begin
                    status_d = STATUS_TMO;
                    state_d  = ST_FINISH;
                end else if (busy_fell) begin
                    status_d = aborting ? STATUS_ABORT : STATUS_OK;
                    state_d  = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        exp_src = (state_q == ST_IDLE) ? exp_ms : exp_q;
        tmr_n   = (state_d == ST_EXPOSE) ? exp_src : MS_W'(SETTLE_MS);
        tmr_clr = (state_d != state_q) && is_timed(state_d);
        tmr_run = is_timed(state_q);
    end

    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_FINISH);
    assign status       = status_q;
    assign ccd_toggle   = (state_q == ST_READ_REQ) || (state_q == ST_FLUSH_REQ);
    assign shutter_open = (state_q == ST_OPEN_SETTLE) || ((state_q == ST_EXPOSE) && !closed_q);
`ifdef EXPSEQ_FLUSH_EN
    assign ccd_mode = ((state_q == ST_FLUSH_REQ) || (state_q == ST_FLUSH_WAIT)) ? MODE_FLUSH
                                                                                : MODE_FULL;
`else
    assign ccd_mode = MODE_FULL;
`endif

endmodule

// File: tb/tb_exposure_sequencer.sv
// Scoreboard bench for exposure_sequencer with a small CCD readout model.
module tb_exposure_sequencer;

    localparam int CPM  = 10;
    localparam int SMS  = 3;
    localparam int TMO  = 16;
    localparam int BLAT = 2;
    localparam int BLEN = 50;
    localparam int RD   = BLAT + BLEN + 1;
`ifdef EXPSEQ_FLUSH_EN
    localparam int F  = 1;
    localparam int FL = RD;
`else
    localparam int F  = 0;
    localparam int FL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        dark = 1'b0;
    logic [23:0] exp_ms = '0;
    logic        ccd_busy = 1'b0;
    logic        ccd_toggle;
    logic [1:0]  ccd_mode;
    logic        shutter_open;
    logic        busy;
    logic        done;
    logic [1:0]  status;

    exposure_sequencer #(.CLK_PER_MS(CPM), .SETTLE_MS(SMS), .BUSY_TMO(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .dark         (dark),
        .exp_ms       (exp_ms),
        .ccd_busy     (ccd_busy),
        .ccd_toggle   (ccd_toggle),
        .ccd_mode     (ccd_mode),
        .shutter_open (shutter_open),
        .busy         (busy),
        .done         (done),
        .status       (status)
    );

    always #5 clk = ~clk;

    typedef struct {
        int status;
        int open_cnt;
        int first_open;
        int toggles;
        int first_tog;
        int last_tog;
        int mode_first;
        int mode_last;
        int done_cyc;
    } seq_t;

    seq_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic seq_t mk(input int st, input int oc, input int fo, input int tg,
                                input int ft, input int lt, input int mf, input int ml,
                                input int dc);
        seq_t s;
        s.status = st; s.open_cnt = oc; s.first_open = fo; s.toggles = tg;
        s.first_tog = ft; s.last_tog = lt; s.mode_first = mf; s.mode_last = ml;
        s.done_cyc = dc;
        return s;
    endfunction

    // CCD model: busy rises 2 cycles after the toggle and stays high for BLEN cycles.
    bit mdl_en = 1'b1;
    int mdl_cnt = 0;
    always @(posedge clk) begin
        if (ccd_toggle && mdl_en) mdl_cnt <= 1;
        else if (mdl_cnt != 0 && mdl_cnt <= BLEN) mdl_cnt <= mdl_cnt + 1;
        else mdl_cnt <= 0;
        ccd_busy <= (mdl_cnt >= 1) && (mdl_cnt <= BLEN);
    end

    // Monitor: cycle 0 is the first cycle with busy high.
    int   seq_cyc = 0;
    bit   was_busy = 1'b0;
    seq_t obs;
    always @(negedge clk) begin
        if (!rst_n) begin
            was_busy = 1'b0;
        end else begin
            if (busy && !was_busy) begin
                seq_cyc = 0;
                obs = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
            end else begin
                seq_cyc++;
            end
            was_busy = busy;
            if (busy) begin
                if (shutter_open) begin
                    if (obs.open_cnt == 0) obs.first_open = seq_cyc;
                    obs.open_cnt++;
                end
                if (ccd_toggle) begin
                    if (obs.toggles == 0) begin
                        obs.first_tog  = seq_cyc;
                        obs.mode_first = int'(ccd_mode);
                    end
                    obs.last_tog  = seq_cyc;
                    obs.mode_last = int'(ccd_mode);
                    obs.toggles++;
                end
                if (done) begin
                    obs.done_cyc = seq_cyc;
                    obs.status   = int'(status);
                    if (sb_q.size() == 0) begin
                        check("done_unexpected", 1, 0);
                    end else begin
                        seq_t e;
                        e = sb_q.pop_front();
                        check("status",     obs.status,     e.status);
                        check("open_cnt",   obs.open_cnt,   e.open_cnt);
                        check("first_open", obs.first_open, e.first_open);
                        check("toggles",    obs.toggles,    e.toggles);
                        check("first_tog",  obs.first_tog,  e.first_tog);
                        check("last_tog",   obs.last_tog,   e.last_tog);
                        check("mode_first", obs.mode_first, e.mode_first);
                        check("mode_last",  obs.mode_last,  e.mode_last);
                        check("done_cyc",   obs.done_cyc,   e.done_cyc);
                    end
                end
            end
        end
    end

    task automatic run_seq(input bit d, input int e, input int abort_at, input int restart_at,
                           input seq_t ex);
        bit ended;
        ended = 1'b0;
        sb_q.push_back(ex);
        dark = d; exp_ms = 24'(e); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3000 && !ended; c++) begin
            if (!busy) begin
                ended = 1'b1;
            end else begin
                abort = (c == abort_at);
                start = (c == restart_at);
                @(negedge clk);
            end
        end
        abort = 1'b0;
        start = 1'b0;
        check("seq_ended", int'(ended), 1);
        check("sb_empty", sb_q.size(), 0);
        sb_q.delete();
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy",    int'(busy), 0);
        check("rst_outputs", int'({ccd_toggle, ccd_mode, shutter_open, done, status}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Normal light frame, exp 5 ms.
        run_seq(0, 5, -1, -1, mk(0, (SMS + 5) * CPM, FL, 1 + F, F ? 0 : FL + 110, FL + 110,
                                F, 0, FL + 110 + RD));
        // Dark frame, exp 4 ms: shutter never opens, no settle phases.
        run_seq(1, 4, -1, -1, mk(0, 0, 0, 1 + F, F ? 0 : FL + 40, FL + 40, F, 0, FL + 40 + RD));
        // Abort 20 cycles into EXPOSE.
        run_seq(0, 5, FL + 50, -1, mk(1, 51, FL, F, 0, 0, F, F, FL + 81));

        // Readout never answers; a start mid-sequence must be ignored.
        mdl_en = 1'b0;
        if (F != 0) run_seq(0, 2, -1, 10, mk(2, 0, 0, 1, 0, 0, 1, 1, TMO));
        else        run_seq(0, 2, -1, 10, mk(2, 50, 0, 1, 80, 80, 0, 0, 80 + TMO));
        check("restart_ignored", int'(busy), 0);
        mdl_en = 1'b1;

        // Abort during READ_WAIT: readout completes before done.
        run_seq(0, 1, FL + 90, -1, mk(1, 40, FL, 1 + F, F ? 0 : FL + 70, FL + 70, F, 0,
                                      FL + 70 + RD));

        // Reset in the middle of EXPOSE.
        dark = 1'b0; exp_ms = 24'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (FL + 40) @(negedge clk);
        check("pre_rst_open", int'(shutter_open), 1);
        rst_n = 1'b0;
        #1;
        check("arst_shutter", int'(shutter_open), 0);
        check("arst_busy",    int'(busy), 0);
        check("arst_status",  int'(status), 0);
        check("arst_other",   int'({ccd_toggle, ccd_mode, done}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Bias frame: exp_ms 0 gives a single closed EXPOSE cycle.
        run_seq(0, 0, -1, -1, mk(0, 0, 0, 1 + F, F ? 0 : FL + 1, FL + 1, F, 0, FL + 1 + RD));

        // start with abort in IDLE: abort wins.
        exp_ms = 24'd3; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
